// File: rtl/fir_pkg.sv
// Shared constants and saturation-bound helpers for the fir_mul_pipe multiplier.
package fir_pkg;

    localparam int MAX_STAGE = 4;

    // Largest value representable in a w-bit two's-complement word.
    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/fir_mul_pipe_stage.sv
// One valid/ready register slice: loads when empty or when its content leaves in the same cycle.
module fir_mul_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             load;

    assign in_ready_o = !valid_q || out_ready_i;
    assign load       = in_valid_i && in_ready_o;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/fir_mul_pipe.sv
// Pipelined signed multiplier with half-up rounding shift and narrowing to DOUT_WIDTH.
// Define FIR_MUL_PIPE_SAT_EN to clamp overflowing results instead of wrapping them.
module fir_mul_pipe
    import fir_pkg::*;
#(
    parameter int DIN0_WIDTH  = 16,
    parameter int DIN1_WIDTH  = 8,
    parameter int DIN1_SIGNED = 0,
    parameter int DOUT_WIDTH  = 23,
    parameter int SHIFT       = 0,
    parameter int NUM_STAGE   = 2
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  ovf
);

    // Stage count is clamped so an out-of-range setting still yields a complete pipe.
    localparam int N_STG   = (NUM_STAGE > MAX_STAGE) ? MAX_STAGE : NUM_STAGE;
    localparam int PW      = DIN0_WIDTH + DIN1_WIDTH + 1;
    localparam int SW      = PW + 1;
    localparam int EW      = (SW > DOUT_WIDTH) ? SW : DOUT_WIDTH;
    localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [SW-1:0] RND     = (SHIFT > 0) ? SW'(longint'(1) <<< RND_POS) : '0;
    localparam logic signed [EW-1:0] SAT_MAX = EW'(sat_max(DOUT_WIDTH));
    localparam logic signed [EW-1:0] SAT_MIN = EW'(sat_min(DOUT_WIDTH));

    logic signed [DIN1_WIDTH:0] din1_x;
    logic signed [PW-1:0]       a_x, b_x, prod;

    assign din1_x = (DIN1_SIGNED != 0) ? {din1[DIN1_WIDTH-1], din1} : {1'b0, din1};
    assign a_x    = PW'($signed(din0));
    assign b_x    = PW'(din1_x);
    assign prod   = a_x * b_x;

    logic signed [PW-1:0]   nar_p;
    logic signed [SW-1:0]   p_x, biased, rnd_r;
    logic signed [EW-1:0]   r_e;
    logic                   nar_ovf;
    logic [DOUT_WIDTH-1:0]  nar_dout;

    // One extra headroom bit keeps the rounding bias from overflowing the product word.
    always_comb begin
        p_x     = SW'(nar_p);
        biased  = p_x + RND;
        rnd_r   = biased >>> SHIFT;
        r_e     = EW'(rnd_r);
        nar_ovf = (r_e > SAT_MAX) || (r_e < SAT_MIN);
`ifdef FIR_MUL_PIPE_SAT_EN
        nar_dout = nar_ovf ? (r_e[EW-1] ? SAT_MIN[DOUT_WIDTH-1:0] : SAT_MAX[DOUT_WIDTH-1:0])
                           : r_e[DOUT_WIDTH-1:0];
`else
        nar_dout = r_e[DOUT_WIDTH-1:0];
`endif
    end

    genvar gi;
    generate
        if (N_STG == 0) begin : g_comb
            assign nar_p     = prod;
            assign out_valid = in_valid;
            assign in_ready  = out_ready;
            assign dout      = nar_dout;
            assign ovf       = nar_ovf;
        end else begin : g_pipe
            // Early slices carry the full product; the last one carries the narrowed result.
            for (gi = 0; gi < N_STG; gi++) begin : g_stage
                localparam int DW_I = (gi == N_STG - 1) ? DOUT_WIDTH + 1 : PW;
                logic            in_vld, in_rdy, out_vld, out_rdy;
                logic [DW_I-1:0] in_dat, out_dat;

                fir_mul_pipe_stage #(.WIDTH(DW_I)) u_stage (
                    .clk         (ap_clk),
                    .srst        (ap_rst),
                    .in_valid_i  (in_vld),
                    .in_ready_o  (in_rdy),
                    .in_data_i   (in_dat),
                    .out_valid_o (out_vld),
                    .out_ready_i (out_rdy),
                    .out_data_o  (out_dat)
                );

                if (gi == 0) begin : g_head
                    assign in_vld   = in_valid;
                    assign in_ready = in_rdy;
                end else begin : g_link
                    assign in_vld = g_stage[gi-1].out_vld;
                end

                if (gi == N_STG - 1) begin : g_tail
                    assign in_dat      = {nar_ovf, nar_dout};
                    assign out_rdy     = out_ready;
                    assign out_valid   = out_vld;
                    assign {ovf, dout} = out_dat;
                end else begin : g_body
                    assign out_rdy = g_stage[gi+1].in_rdy;
                    if (gi == 0) begin : g_src
                        assign in_dat = prod;
                    end else begin : g_fwd
                        assign in_dat = g_stage[gi-1].out_dat;
                    end
                end
            end

            if (N_STG == 1) begin : g_nar_direct
                assign nar_p = prod;
            end else begin : g_nar_piped
                assign nar_p = g_stage[N_STG-2].out_dat;
            end
        end
    endgenerate

endmodule

// File: tb/tb_fir_mul_pipe.sv
// Scoreboard bench: three configurations of fir_mul_pipe driven in lockstep, checked by a decoupled monitor.
module tb_fir_mul_pipe;

`ifdef FIR_MUL_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [22:0] d;
        logic        o;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        int          ea, eas;
        bit          oa;
        int          eb;
        int          ec, ecs;
        bit          oc;
    } vec_t;

    logic clk = 1'b0;
    logic ap_rst, drv_v, out_ready, in_v;
    logic [15:0] din0;
    logic [7:0]  din1;
    logic [2:0]  ir, ov, of;
    logic [2:0][22:0] dt;
    logic all_rdy;

    assign all_rdy = &ir;
    assign in_v    = drv_v & all_rdy;

    initial forever #5 clk = ~clk;

    // A: defaults.  B: SHIFT=4, 3 stages.  C: signed din1, 4 stages.
    fir_mul_pipe #(.DIN0_WIDTH(16), .DIN1_WIDTH(8), .DIN1_SIGNED(0), .DOUT_WIDTH(23),
                   .SHIFT(0), .NUM_STAGE(2)) u_a (
        .ap_clk(clk), .ap_rst(ap_rst), .in_valid(in_v), .in_ready(ir[0]), .din0(din0), .din1(din1),
        .out_valid(ov[0]), .out_ready(out_ready), .dout(dt[0]), .ovf(of[0]));
    fir_mul_pipe #(.DIN0_WIDTH(16), .DIN1_WIDTH(8), .DIN1_SIGNED(0), .DOUT_WIDTH(23),
                   .SHIFT(4), .NUM_STAGE(3)) u_b (
        .ap_clk(clk), .ap_rst(ap_rst), .in_valid(in_v), .in_ready(ir[1]), .din0(din0), .din1(din1),
        .out_valid(ov[1]), .out_ready(out_ready), .dout(dt[1]), .ovf(of[1]));
    fir_mul_pipe #(.DIN0_WIDTH(16), .DIN1_WIDTH(8), .DIN1_SIGNED(1), .DOUT_WIDTH(23),
                   .SHIFT(0), .NUM_STAGE(4)) u_c (
        .ap_clk(clk), .ap_rst(ap_rst), .in_valid(in_v), .in_ready(ir[2]), .din0(din0), .din1(din1),
        .out_valid(ov[2]), .out_ready(out_ready), .dout(dt[2]), .ovf(of[2]));

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   lat_on = 1'b0;
    bit   in_reset = 1'b1;
    bit   rand_mode = 1'b0;
    exp_t q_a[$], q_b[$], q_c[$];
    vec_t vt[10];
    logic [2:0] stall_prev = '0;
    logic [2:0] o_prev;
    logic [2:0][22:0] d_prev;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_mode) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string nm, input logic signed [63:0] got, input logic signed [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    function automatic logic signed [63:0] sx(input logic [22:0] x);
        return 64'($signed(x));
    endfunction

    function automatic int ns(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 3 : 4);
    endfunction

    function automatic vec_t mkv(input int a, input int b, input int ea, input int eas, input bit oa,
                                 input int eb, input int ec, input int ecs, input bit oc);
        vec_t v;
        v.a = a[15:0]; v.b = b[7:0];
        v.ea = ea; v.eas = eas; v.oa = oa; v.eb = eb;
        v.ec = ec; v.ecs = ecs; v.oc = oc;
        return v;
    endfunction

    function automatic exp_t mk_exp(input int wrap_v, input int sat_v, input bit o);
        exp_t e;
        int   v;
        v     = (SAT && o) ? sat_v : wrap_v;
        e.d   = v[22:0];
        e.o   = o;
        e.cyc = 0;
        return e;
    endfunction

    // Independent reference: exact product, half-up rounding, 23-bit range check.
    function automatic exp_t model(input int shift, input bit sgn, input logic [15:0] a, input logic [7:0] b);
        exp_t   e;
        longint p, r;
        p = longint'($signed(a)) * (sgn ? longint'($signed(b)) : longint'(b));
        if (shift > 0) r = (p + (longint'(1) <<< (shift - 1))) >>> shift;
        else           r = p;
        e.o   = (r > 64'sd4194303) || (r < -64'sd4194304);
        e.d   = r[22:0];
        if (SAT && e.o) e.d = (r > 0) ? 23'h3FFFFF : 23'h400000;
        e.cyc = 0;
        return e;
    endfunction

    task automatic pop_exp(input int i, output exp_t e, output bit ok);
        ok = 1'b0;
        e  = '{d: '0, o: 1'b0, cyc: 0};
        case (i)
            0: if (q_a.size() > 0) begin e = q_a.pop_front(); ok = 1'b1; end
            1: if (q_b.size() > 0) begin e = q_b.pop_front(); ok = 1'b1; end
            default: if (q_c.size() > 0) begin e = q_c.pop_front(); ok = 1'b1; end
        endcase
    endtask

    task automatic mon(input int i);
        exp_t e;
        bit   ok;
        if (in_reset) begin
            stall_prev[i] = 1'b0;
            return;
        end
        if (stall_prev[i]) begin
            chk($sformatf("hold_valid%0d", i), 64'(ov[i]), 64'sd1);
            chk($sformatf("hold_dout%0d", i), sx(dt[i]), sx(d_prev[i]));
            chk($sformatf("hold_ovf%0d", i), 64'(of[i]), 64'(o_prev[i]));
        end
        if (ov[i] && out_ready) begin
            pop_exp(i, e, ok);
            chk($sformatf("expected_out%0d", i), 64'(ok), 64'sd1);
            if (ok) begin
                $display("out dut%0d cyc=%0d dout=%0d ovf=%0d", i, cyc, $signed(dt[i]), of[i]);
                chk($sformatf("dout%0d", i), sx(dt[i]), sx(e.d));
                chk($sformatf("ovf%0d", i), 64'(of[i]), 64'(e.o));
                if (lat_on) chk($sformatf("latency%0d", i), 64'(cyc - e.cyc), 64'(ns(i)));
            end
        end
        stall_prev[i] = ov[i] && !out_ready;
        d_prev[i]     = dt[i];
        o_prev[i]     = of[i];
    endtask

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) mon(i);
    end

    // Entered and left at posedge+1; leaves drv_v high so back-to-back calls run at full rate.
    task automatic send(input logic [15:0] a, input logic [7:0] b, input exp_t ea, input exp_t eb, input exp_t ec);
        int n = 0;
        drv_v = 1'b1;
        din0  = a;
        din1  = b;
        forever begin
            @(negedge clk);
            if (all_rdy) begin
                ea.cyc = cyc; eb.cyc = cyc; ec.cyc = cyc;
                q_a.push_back(ea); q_b.push_back(eb); q_c.push_back(ec);
                $display("in  cyc=%0d din0=%0d din1=%0d", cyc, $signed(a), b);
                break;
            end
            n++;
            if (n > 200) begin
                total++;
                bad++;
                $display("FAIL accept_timeout waited=%0d limit=200", n);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_vec(input vec_t v);
        send(v.a, v.b, mk_exp(v.ea, v.eas, v.oa), mk_exp(v.eb, v.eb, 1'b0), mk_exp(v.ec, v.ecs, v.oc));
    endtask

    task automatic drain();
        int n = 0;
        drv_v = 1'b0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((q_a.size() + q_b.size() + q_c.size()) > 0 && n < 200);
        chk("drain_left", 64'(q_a.size() + q_b.size() + q_c.size()), 64'sd0);
    endtask

    initial begin
        vt[0] = mkv(100, 3, 300, 300, 0, 19, 300, 300, 0);
        vt[1] = mkv(1000, 3, 3000, 3000, 0, 188, 3000, 3000, 0);
        vt[2] = mkv(-1000, 3, -3000, -3000, 0, -187, -3000, -3000, 0);
        vt[3] = mkv(-2, 255, -510, -510, 0, -32, 2, 2, 0);
        vt[4] = mkv(-32768, 255, 32768, -4194304, 1, -522240, 32768, 32768, 0);
        vt[5] = mkv(32767, 255, -33023, 4194303, 1, 522224, -32767, -32767, 0);
        vt[6] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        vt[7] = mkv(-32768, 128, -4194304, -4194304, 0, -262144, -4194304, 4194303, 1);
        vt[8] = mkv(8, 1, 8, 8, 0, 1, 8, 8, 0);
        vt[9] = mkv(-8, 1, -8, -8, 0, 0, -8, -8, 0);

        ap_rst = 1'b1; drv_v = 1'b0; out_ready = 1'b1; din0 = '0; din1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_valid%0d", i), 64'(ov[i]), 64'sd0);
            chk($sformatf("rst_dout%0d", i), sx(dt[i]), 64'sd0);
            chk($sformatf("rst_ovf%0d", i), 64'(of[i]), 64'sd0);
        end
        @(posedge clk);
        #1 ap_rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk($sformatf("ready_after_rst%0d", i), 64'(ir[i]), 64'sd1);
        in_reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed vectors, consumer always ready, so every result must show exact latency.
        lat_on = 1'b1;
        for (int i = 0; i < 10; i++) send_vec(vt[i]);
        drain();

        // Random stream with 50% consumer stalls.
        lat_on    = 1'b0;
        rand_mode = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [15:0] ra;
            logic [7:0]  rb;
            ra = 16'($urandom);
            rb = 8'($urandom);
            send(ra, rb, model(0, 1'b0, ra, rb), model(4, 1'b0, ra, rb), model(0, 1'b1, ra, rb));
        end
        drain();
        rand_mode = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b0;

        // Two results in flight behind a stalled consumer, then reset.
        send_vec(vt[2]);
        send_vec(vt[3]);
        drv_v = 1'b0;
        @(posedge clk);
        #1;
        in_reset = 1'b1;
        ap_rst   = 1'b1;
        @(posedge clk);
        #1;
        ap_rst = 1'b0;
        q_a.delete(); q_b.delete(); q_c.delete();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("flush_valid%0d", i), 64'(ov[i]), 64'sd0);
            chk($sformatf("flush_dout%0d", i), sx(dt[i]), 64'sd0);
            chk($sformatf("flush_ready%0d", i), 64'(ir[i]), 64'sd1);
        end
        in_reset = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        lat_on    = 1'b1;
        send_vec(vt[1]);
        drain();
        repeat (8) @(posedge clk);
        #1;
        chk("stale_left", 64'(q_a.size() + q_b.size() + q_c.size()), 64'sd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
